main_control_fsm: RTL
=====================

// Module: main_control_fsm
// PURPOSE
//  Multi-cycle MIPS main control unit: sequences each instruction through fetch/decode/execute
//  states and drives datapath enables plus the 2-bit aluop consumed by the downstream ALU control.
//  Sits upstream of alu_control; aluop codes: 00 add, 01 sub, 10 use funct, 11 add (immediate).
// PARAMETERS
//  none (encodings fixed in shared package)
// PORTS
//  clk            in   1  single clock, rising edge
//  reset_n        in   1  asynchronous, active-low reset
//  opcode         in   6  IR[31:26]; IR is written only via ir_write, so stable after FETCH
//  mem_ready      in   1  memory handshake: access completes in the cycle this is 1
//  iord           out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  load IR
//  reg_dst        out  1  0 = rt, 1 = rd write register
//  mem_to_reg     out  1  1 = write-back data from MDR, 0 = from ALUOut
//  reg_write      out  1  register file write enable
//  alu_src_a      out  1  0 = PC, 1 = A
//  alu_src_b      out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  aluop          out  2  to alu_control
//  pc_src         out  2  00 ALU result, 01 ALUOut, 10 jump target
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load qualified by ALU zero (datapath ANDs)
//  halted         out  1  1 in S_HALT
//  state          out  4  current state, for debug/bench
// BEHAVIOUR
//  - Moore decode of 4-bit state reg; only ir_write/pc_write in FETCH and transitions use mem_ready.
//  - Reset (reset_n low, async): state = S_RST (4'd12); all outputs 0. S_RST -> S_FETCH next clock.
//  - Outputs not listed for a state are 0.
//  - S_FETCH: mem_read=1, alu_src_b=01, aluop=00; ir_write=pc_write=mem_ready. Stay until mem_ready=1, then S_DECODE.
//  - S_DECODE: alu_src_b=11, aluop=00 (branch target into ALUOut). Next by opcode:
//      6'h00 -> S_EXEC; 6'h23/6'h2B -> S_MEMADR; 6'h04 -> S_BEQ; 6'h02 -> S_JUMP;
//      6'h08 -> S_ADDI_EX (only with macro); any other -> S_HALT.
//  - S_MEMADR: alu_src_a=1, alu_src_b=10, aluop=00; opcode 23 -> S_MEMRD, else S_MEMWR.
//  - S_MEMRD: iord=1, mem_read=1; hold until mem_ready, then S_MEMWB.
//  - S_MEMWB: mem_to_reg=1, reg_write=1 -> S_FETCH.
//  - S_MEMWR: iord=1, mem_write=1; hold until mem_ready, then S_FETCH.
//  - S_EXEC: alu_src_a=1, alu_src_b=00, aluop=10 -> S_ALUWB.  S_ALUWB: reg_dst=1, reg_write=1 -> S_FETCH.
//  - S_BEQ: alu_src_a=1, aluop=01, pc_src=01, pc_write_cond=1 -> S_FETCH.
//  - S_JUMP: pc_src=10, pc_write=1 -> S_FETCH.
//  - S_HALT: halted=1, sticky until reset; no memory or register activity.
//  - Unused encodings (13,14) -> S_HALT. Reset mid-access aborts immediately; no write completes.
//  - Cycles with mem_ready=1 always: R 4, lw 5, sw 4, beq 3, j 3, addi 4.
// CONFIGURATION
//  MAIN_CTL_ADDI_EN defined: opcode 6'h08 -> S_ADDI_EX (alu_src_a=1, alu_src_b=10, aluop=11)
//   -> S_ADDI_WB (reg_dst=0, mem_to_reg=0, reg_write=1) -> S_FETCH.
//  Undefined: states 9/10 absent; opcode 6'h08 is illegal -> S_HALT.
// STRUCTURE
//  Package mips_ctl_pkg: state localparams (FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5,
//   EXEC 6, ALUWB 7, BEQ 8, ADDI_EX 9, ADDI_WB 10, JUMP 11, RST 12, HALT 15), opcode constants,
//   aluop codes, alu_src_b/pc_src encodings; shared with alu_control.
//  One sub-module: main_control_decode (combinational state + mem_ready -> output vector).
// TESTING
//  1 reset_n low with mem_ready=1 -> all outputs 0, state=12; release -> state 0 next clock.
//  2 opcode 0, mem_ready=1 -> states 0,1,6,7,0; aluop 00,00,10,00; reg_write/reg_dst=1 only in 7.
//  3 opcode 23, mem_ready low 3 cycles in S_MEMRD -> stays in 3 for 3 cycles, mem_to_reg=1 in 4; 8 cycles total.
//  4 opcode 04 -> S_BEQ with aluop=01, pc_write_cond=1, pc_src=01; opcode 02 -> pc_write=1, pc_src=10.
//  5 opcode 08: macro on -> 9 (aluop=11), 10, 0; macro off -> S_HALT, halted=1 held 10 cycles.
//  6 reset_n pulled low mid S_MEMWR -> mem_write drops asynchronously, restart via 12 -> 0.

Source files
------------

// File: rtl/mips_ctl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path (main control FSM and alu_control).
// Optional addi support in the FSM is selected by the MAIN_CTL_ADDI_EN macro.
package mips_ctl_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_ADDI_EX = 4'd9;
  localparam logic [3:0] S_ADDI_WB = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_RST     = 4'd12;
  localparam logic [3:0] S_HALT    = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [1:0] ALUB_B      = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       halted;
  } ctl_t;

  function automatic ctl_t ctl_idle();
    ctl_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/main_control_decode.sv
// Combinational Moore decode of the control state into datapath enables.
// States 9/10 decode only when MAIN_CTL_ADDI_EN is defined.
module main_control_decode
  import mips_ctl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctl_t       ctl
);

  // Per-state output vector; anything not named stays 0
  always_comb begin
    ctl = ctl_idle();
    case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = ALUB_FOUR;
        ctl.aluop     = ALUOP_ADD;
        ctl.pc_src    = PCSRC_ALU;
        // IR and PC may only load in the cycle the fetch actually completes
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctl.alu_src_b = ALUB_IMM_SH;
        ctl.aluop     = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_IMM;
        ctl.aluop     = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctl.iord     = 1'b1;
        ctl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_B;
        ctl.aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
      end
      S_BEQ: begin
        ctl.alu_src_a     = 1'b1;
        ctl.aluop         = ALUOP_SUB;
        ctl.pc_src        = PCSRC_ALUOUT;
        ctl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_src   = PCSRC_JUMP;
        ctl.pc_write = 1'b1;
      end
`ifdef MAIN_CTL_ADDI_EN
      S_ADDI_EX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_IMM;
        ctl.aluop     = ALUOP_ADDI;
      end
      S_ADDI_WB: begin
        ctl.reg_write = 1'b1;
      end
`endif
      S_HALT: begin
        ctl.halted = 1'b1;
      end
      default: begin
        ctl = ctl_idle();
      end
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic and output decode.
// Define MAIN_CTL_ADDI_EN to sequence addi (opcode 6'h08) instead of halting on it.
module main_control_fsm
  import mips_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       halted,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctl_t       ctl_s;

  // Next-state selection; memory states wait on mem_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BEQ;
          OP_J:          state_d = S_JUMP;
`ifdef MAIN_CTL_ADDI_EN
          OP_ADDI:       state_d = S_ADDI_EX;
`endif
          default:       state_d = S_HALT;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BEQ:     state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
`ifdef MAIN_CTL_ADDI_EN
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ADDI_WB: state_d = S_FETCH;
`endif
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_HALT;
    endcase
  end

  // State register; async reset lands in S_RST so all outputs drop at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  main_control_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctl       (ctl_s)
  );

  assign iord          = ctl_s.iord;
  assign mem_read      = ctl_s.mem_read;
  assign mem_write     = ctl_s.mem_write;
  assign ir_write      = ctl_s.ir_write;
  assign reg_dst       = ctl_s.reg_dst;
  assign mem_to_reg    = ctl_s.mem_to_reg;
  assign reg_write     = ctl_s.reg_write;
  assign alu_src_a     = ctl_s.alu_src_a;
  assign alu_src_b     = ctl_s.alu_src_b;
  assign aluop         = ctl_s.aluop;
  assign pc_src        = ctl_s.pc_src;
  assign pc_write      = ctl_s.pc_write;
  assign pc_write_cond = ctl_s.pc_write_cond;
  assign halted        = ctl_s.halted;
  assign state         = state_q;

endmodule
